// File: rtl/enc_tx_sequencer.sv
// Framing sequencer in front of an 8B10B encoder: link init commas, SOF/EOF
// delimiting, idle fill and periodic K28.5 alignment insertion.
module enc_tx_sequencer #(
  parameter int unsigned INIT_LEN     = 16,
  parameter int unsigned ALIGN_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       link_en,
  input  logic [7:0] s_data,
  input  logic       s_valid,
  input  logic       s_last,
  output logic       s_ready,
  output logic [7:0] enc_din,
  output logic       enc_k,
  output logic       enc_ena,
  output logic       link_up
);

  localparam int unsigned IW = 8;
  localparam int unsigned AW = (ALIGN_PERIOD > 2) ? $clog2(ALIGN_PERIOD) : 1;

  localparam logic [7:0]    K_COMMA = 8'hBC;
  localparam logic [7:0]    K_SOF   = 8'hFB;
  localparam logic [7:0]    K_EOF   = 8'hFD;
  localparam logic [7:0]    K_FILL  = 8'h1C;
  localparam logic [IW-1:0] INIT_MAX  = IW'(INIT_LEN - 1);
  localparam logic [AW-1:0] ALIGN_MAX = AW'(ALIGN_PERIOD - 1);

  typedef enum logic [2:0] {
    ST_INIT, ST_IDLE, ST_SOF, ST_DATA, ST_ALIGN, ST_EOF
  } state_t;

  state_t          state;
  logic [IW-1:0]   init_cnt;
  logic [AW-1:0]   align_cnt;
  logic [AW-1:0]   align_inc;
  logic            align_due;
  logic            xfer;

  assign align_due = (align_cnt >= ALIGN_MAX);
  assign align_inc = align_due ? align_cnt : AW'(align_cnt + AW'(1));
  assign s_ready   = (state == ST_DATA) & link_en & ~align_due;
  assign xfer      = s_valid & s_ready;

  // The DATA cycle that finds the alignment due already emits the comma, so
  // no run between commas inside a frame ever exceeds ALIGN_PERIOD-1.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_INIT;
      init_cnt  <= '0;
      align_cnt <= '0;
      enc_din   <= 8'h00;
      enc_k     <= 1'b0;
      enc_ena   <= 1'b0;
      link_up   <= 1'b0;
    end else if (!link_en) begin
      enc_ena <= 1'b0;
    end else begin
      enc_ena <= 1'b1;
      enc_k   <= 1'b1;
      case (state)
        ST_INIT: begin
          enc_din   <= K_COMMA;
          align_cnt <= '0;
          if (init_cnt == INIT_MAX) begin
            state   <= ST_IDLE;
            link_up <= 1'b1;
          end else begin
            init_cnt <= IW'(init_cnt + IW'(1));
          end
        end
        ST_IDLE: begin
          enc_din   <= K_COMMA;
          align_cnt <= '0;
          if (s_valid) state <= ST_SOF;
        end
        ST_SOF: begin
          enc_din   <= K_SOF;
          align_cnt <= align_inc;
          state     <= ST_DATA;
        end
        ST_DATA: begin
          if (align_due) begin
            enc_din   <= K_COMMA;
            align_cnt <= '0;
            state     <= ST_ALIGN;
          end else if (xfer) begin
            enc_din   <= s_data;
            enc_k     <= 1'b0;
            align_cnt <= align_inc;
            if (s_last) state <= ST_EOF;
          end else begin
            enc_din   <= K_FILL;
            align_cnt <= align_inc;
          end
        end
        ST_ALIGN: begin
          enc_din   <= K_COMMA;
          align_cnt <= '0;
          state     <= ST_DATA;
        end
        ST_EOF: begin
          enc_din   <= K_EOF;
          align_cnt <= align_inc;
          state     <= ST_IDLE;
        end
        default: begin
          enc_din <= K_COMMA;
          state   <= ST_INIT;
        end
      endcase
    end
  end

endmodule
